// File: rtl/m_dmx4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer.
//   in_*  : single upstream valid/ready stream (valid, ready, data, last, sel)
//   out_* : four downstream valid/ready channels; channel k payload is
//           out_data[k*DW +: DW]
// master: the side that sources the input stream and sinks the channels.
// slave : the demultiplexer itself.
interface m_dmx4_stream_if #(
  parameter int unsigned DW = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_last;
  logic [1:0]        in_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [4*DW-1:0]   out_data;
  logic [3:0]        out_last;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/m_dmx4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with packet-locked select.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : stream bundle (slave side), see m_dmx4_stream_if
//   busy    : high while a packet is open (between first and last beat)
//   cur_sel : effective channel; locked channel when busy, else in_sel
// Each channel owns a one-entry output register so channels drain
// independently and no combinational path runs from in_valid to in_ready.
module m_dmx4_stream #(
  parameter int unsigned DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  m_dmx4_stream_if.slave     bus,
  output logic               busy,
  output logic [1:0]         cur_sel
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] lock_sel_q, lock_sel_d;

  logic [1:0] csel;
  logic       in_ready_c;
  logic       accept;
  logic [3:0] load;
  logic [3:0] vld_all;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Next-state logic: select is captured only on the opening beat of a
  // multi-beat packet; single-beat packets never leave IDLE.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.in_last) begin
            state_d    = BUSY;
            lock_sel_d = bus.in_sel;
          end
        end
        BUSY: begin
          if (bus.in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / steering logic
  always_comb begin
    csel       = (state_q == IDLE) ? bus.in_sel : lock_sel_q;
    // Ready if the target slot is empty or is being drained this cycle.
    in_ready_c = ~vld_all[csel] | bus.out_ready[csel];
    accept     = bus.in_valid & in_ready_c;
    load       = '0;
    if (accept) begin
      load[csel] = 1'b1;
    end
    bus.in_ready = in_ready_c;
    busy         = (state_q == BUSY);
    cur_sel      = csel;
  end

  // Per-channel output registers. A load takes priority over a drain, so a
  // simultaneous drain+load keeps the slot full with the new beat.
  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic          vld_q;
    logic [DW-1:0] data_q;
    logic          last_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        last_q <= 1'b0;
      end else if (load[k]) begin
        vld_q  <= 1'b1;
        data_q <= bus.in_data;
        last_q <= bus.in_last;
      end else if (bus.out_ready[k]) begin
        vld_q  <= 1'b0;
      end
    end

    assign vld_all[k]                  = vld_q;
    assign bus.out_valid[k]            = vld_q;
    assign bus.out_data[k*DW +: DW]    = data_q;
    assign bus.out_last[k]             = last_q;
  end

endmodule
